// File: rtl/mem_burst_arbiter_if.sv
// Cache-side and BRAM-side signals of the burst arbiter.
// The arbiter takes the slave view; the caches and BRAM together take the master view.
interface mem_burst_arbiter_if #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 16,
  parameter int BLOCK_OFFSET_WIDTH = 5
);
  logic                          ic_req;
  logic [ADDR_WIDTH-1:0]         ic_addr;
  logic [DATA_WIDTH-1:0]         ic_read;
  logic                          ic_read_valid;
  logic                          ic_last;

  logic                          dc_req;
  logic                          dc_we;
  logic [ADDR_WIDTH-1:0]         dc_addr;
  logic [DATA_WIDTH-1:0]         dc_wdata;
  logic                          dc_wnext;
  logic [BLOCK_OFFSET_WIDTH-1:0] dc_woffset;
  logic [DATA_WIDTH-1:0]         dc_read;
  logic                          dc_read_valid;
  logic                          dc_last;

  logic                          bram_en;
  logic                          bram_we;
  logic [ADDR_WIDTH-1:0]         bram_addr;
  logic [DATA_WIDTH-1:0]         bram_wdata;
  logic [DATA_WIDTH-1:0]         bram_rdata;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, bram_rdata,
    output ic_read, ic_read_valid, ic_last,
    output dc_wnext, dc_woffset, dc_read, dc_read_valid, dc_last,
    output bram_en, bram_we, bram_addr, bram_wdata
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, bram_rdata,
    input  ic_read, ic_read_valid, ic_last,
    input  dc_wnext, dc_woffset, dc_read, dc_read_valid, dc_last,
    input  bram_en, bram_we, bram_addr, bram_wdata
  );
endinterface

// File: rtl/mem_burst_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between the I-cache and D-cache,
// issuing one aligned full-block burst per grant.
//
// state | meaning
// IDLE  | no burst; arbitrate and latch grant, base address and direction
// BURST | issue BLOCK_SIZE sequential BRAM accesses
// DRAIN | read only: wait for the last word to come back from the BRAM
module mem_burst_arbiter #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 16,
  parameter int BLOCK_OFFSET_WIDTH = 5,
  parameter int READ_LATENCY       = 1
) (
  input logic               clk,
  input logic               rst,
  mem_burst_arbiter_if.slave bus
);
  localparam int AW = ADDR_WIDTH;
  localparam int OW = BLOCK_OFFSET_WIDTH;
  localparam int BW = AW - OW;
  localparam logic [OW-1:0] LAST_OFF = '1;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t                  state;
  logic                    grant_dc;
  logic                    burst_we;
  logic [BW-1:0]           base;
  logic [OW-1:0]           cnt;
  logic [OW-1:0]           rcnt;
  logic [READ_LATENCY-1:0] vpipe;
  logic                    bram_en_r;
  logic                    bram_we_r;
  logic [AW-1:0]           bram_addr_r;
  logic                    dc_wnext_r;
  logic [OW-1:0]           dc_woffset_r;
  logic                    dc_wlast_r;

  logic          pick_dc;
  logic [BW-1:0] pick_base;
  logic [OW-1:0] cnt_nxt;
  logic          pipe_out;
  logic          rd_last;
  logic          unused_offsets;

  // grant_dc also serves as last_grant: a tie goes to whoever was not served last
  assign pick_dc   = bus.dc_req && (!bus.ic_req || !grant_dc);
  assign pick_base = pick_dc ? bus.dc_addr[AW-1:OW] : bus.ic_addr[AW-1:OW];
  assign cnt_nxt   = cnt + 1'b1;
  assign pipe_out  = vpipe[READ_LATENCY-1];
  assign rd_last   = pipe_out && (rcnt == LAST_OFF);
  assign unused_offsets = ^{bus.ic_addr[OW-1:0], bus.dc_addr[OW-1:0]};

  assign bus.bram_en       = bram_en_r;
  assign bus.bram_we       = bram_we_r;
  assign bus.bram_addr     = bram_addr_r;
  assign bus.bram_wdata    = bus.dc_wdata;
  assign bus.dc_wnext      = dc_wnext_r;
  assign bus.dc_woffset    = dc_woffset_r;
  assign bus.ic_read       = bus.bram_rdata;
  assign bus.dc_read       = bus.bram_rdata;
  assign bus.ic_read_valid = pipe_out && !grant_dc;
  assign bus.ic_last       = rd_last && !grant_dc;
  assign bus.dc_read_valid = pipe_out && grant_dc;
  assign bus.dc_last       = (rd_last && grant_dc) || dc_wlast_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      grant_dc     <= 1'b1;
      burst_we     <= 1'b0;
      base         <= '0;
      cnt          <= '0;
      rcnt         <= '0;
      vpipe        <= '0;
      bram_en_r    <= 1'b0;
      bram_we_r    <= 1'b0;
      bram_addr_r  <= '0;
      dc_wnext_r   <= 1'b0;
      dc_woffset_r <= '0;
      dc_wlast_r   <= 1'b0;
    end else begin
      // each read issue is tagged so the return strobe lines up with bram_rdata
      vpipe[0] <= bram_en_r && !bram_we_r;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
      end
      if (pipe_out) begin
        rcnt <= rcnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.ic_req || bus.dc_req) begin
            grant_dc     <= pick_dc;
            burst_we     <= pick_dc && bus.dc_we;
            base         <= pick_base;
            cnt          <= '0;
            rcnt         <= '0;
            bram_en_r    <= 1'b1;
            bram_we_r    <= pick_dc && bus.dc_we;
            bram_addr_r  <= {pick_base, {OW{1'b0}}};
            dc_wnext_r   <= pick_dc && bus.dc_we;
            dc_woffset_r <= '0;
            dc_wlast_r   <= 1'b0;
            state        <= BURST;
          end
        end
        BURST: begin
          if (cnt == LAST_OFF) begin
            cnt          <= '0;
            bram_en_r    <= 1'b0;
            bram_we_r    <= 1'b0;
            dc_wnext_r   <= 1'b0;
            dc_woffset_r <= '0;
            dc_wlast_r   <= 1'b0;
            state        <= burst_we ? IDLE : DRAIN;
          end else begin
            cnt          <= cnt_nxt;
            bram_addr_r  <= {base, cnt_nxt};
            dc_woffset_r <= burst_we ? cnt_nxt : '0;
            dc_wlast_r   <= burst_we && (cnt_nxt == LAST_OFF);
          end
        end
        DRAIN: begin
          if (rd_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Directed bench for mem_burst_arbiter: two instances (read latency 1 and 2),
// each with a behavioural BRAM whose unwritten words read as 0xA5A50000|addr.
module tb_mem_burst_arbiter;
  logic clk = 1'b0;
  logic rst;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_burst_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .BLOCK_OFFSET_WIDTH(5)) bus1 ();
  mem_burst_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .BLOCK_OFFSET_WIDTH(5)) bus2 ();

  mem_burst_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .BLOCK_OFFSET_WIDTH(5), .READ_LATENCY(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_burst_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .BLOCK_OFFSET_WIDTH(5), .READ_LATENCY(2))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  bit [31:0] mem1 [65536];
  bit        wr1  [65536];
  logic [31:0] rd2_stage;

  always_comb bus1.dc_wdata = 32'hD000_0000 + 32'(bus1.dc_woffset);
  assign bus2.dc_wdata = 32'h0;

  always @(posedge clk) begin
    if (bus1.bram_en) begin
      if (bus1.bram_we) begin
        mem1[bus1.bram_addr] <= bus1.bram_wdata;
        wr1[bus1.bram_addr]  <= 1'b1;
      end else begin
        bus1.bram_rdata <= wr1[bus1.bram_addr] ? mem1[bus1.bram_addr]
                                               : (32'hA5A5_0000 | {16'h0, bus1.bram_addr});
      end
    end
  end

  always @(posedge clk) begin
    if (bus2.bram_en && !bus2.bram_we) begin
      rd2_stage <= 32'hA5A5_0000 | {16'h0, bus2.bram_addr};
    end
    bus2.bram_rdata <= rd2_stage;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet1(input string tag);
    check({tag, " ic_valid"}, 32'(bus1.ic_read_valid), 32'd0);
    check({tag, " ic_last"},  32'(bus1.ic_last), 32'd0);
    check({tag, " dc_valid"}, 32'(bus1.dc_read_valid), 32'd0);
    check({tag, " dc_last"},  32'(bus1.dc_last), 32'd0);
    check({tag, " wnext"},    32'(bus1.dc_wnext), 32'd0);
    check({tag, " en"},       32'(bus1.bram_en), 32'd0);
    check({tag, " we"},       32'(bus1.bram_we), 32'd0);
  endtask

  // Called at the negedge of the IDLE cycle in which the request is visible.
  // Walks cycles 1..33 after it: issues on 1..32, returns on 2..33, last on 33.
  task automatic burst_read1(input string tag, input bit is_dc, input logic [15:0] base);
    logic [15:0] ea;
    logic v, l, ov, ol;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      check($sformatf("%s en k%0d", tag, k), 32'(bus1.bram_en), 32'(k <= 32));
      check($sformatf("%s we k%0d", tag, k), 32'(bus1.bram_we), 32'd0);
      if (k <= 32) begin
        ea = base + 16'(k - 1);
        check($sformatf("%s addr k%0d", tag, k), 32'(bus1.bram_addr), 32'(ea));
      end
      v  = is_dc ? bus1.dc_read_valid : bus1.ic_read_valid;
      l  = is_dc ? bus1.dc_last : bus1.ic_last;
      ov = is_dc ? bus1.ic_read_valid : bus1.dc_read_valid;
      ol = is_dc ? bus1.ic_last : bus1.dc_last;
      check($sformatf("%s valid k%0d", tag, k), 32'(v), 32'(k >= 2));
      check($sformatf("%s last k%0d", tag, k), 32'(l), 32'(k == 33));
      check($sformatf("%s other_valid k%0d", tag, k), 32'(ov), 32'd0);
      check($sformatf("%s other_last k%0d", tag, k), 32'(ol), 32'd0);
      check($sformatf("%s wnext k%0d", tag, k), 32'(bus1.dc_wnext), 32'd0);
      if (k >= 2) begin
        ea = base + 16'(k - 2);
        check($sformatf("%s data k%0d", tag, k),
              is_dc ? bus1.dc_read : bus1.ic_read, 32'hA5A5_0000 | {16'h0, ea});
      end
      if (k == 33) begin
        if (is_dc) bus1.dc_req = 1'b0;
        else       bus1.ic_req = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    int first_en, first_icv, ic_last_k, dc_first_en, dc_last_k, icv_cnt, icd_ok, dcv_cnt;
    logic [15:0] ea;

    rst = 1'b1;
    bus1.ic_req = 0; bus1.ic_addr = '0; bus1.dc_req = 0; bus1.dc_we = 0; bus1.dc_addr = '0;
    bus2.ic_req = 0; bus2.ic_addr = '0; bus2.dc_req = 0; bus2.dc_we = 0; bus2.dc_addr = '0;
    repeat (2) @(negedge clk);
    check_quiet1("reset");
    check("reset dut2 en", 32'(bus2.bram_en), 32'd0);
    check("reset dut2 ic_valid", 32'(bus2.ic_read_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_quiet1("post_reset");

    // tie after reset: IC first, DC in the IDLE cycle after ic_last
    bus1.ic_addr = 16'h0040; bus1.dc_addr = 16'h0200; bus1.dc_we = 0;
    bus1.ic_req = 1; bus1.dc_req = 1;
    burst_read1("t2a_ic", 1'b0, 16'h0040);
    @(negedge clk);
    check("t2a gap en", 32'(bus1.bram_en), 32'd0);
    burst_read1("t2a_dc", 1'b1, 16'h0200);
    @(negedge clk);
    check_quiet1("t2a idle");

    // IC alone, aligned block 0x0120
    bus1.ic_addr = 16'h0120; bus1.ic_req = 1;
    burst_read1("t1", 1'b0, 16'h0120);
    @(negedge clk);

    // tie after an IC burst: DC first
    bus1.ic_addr = 16'h0040; bus1.dc_addr = 16'h0200;
    bus1.ic_req = 1; bus1.dc_req = 1;
    burst_read1("t2b_dc", 1'b1, 16'h0200);
    @(negedge clk);
    check("t2b gap en", 32'(bus1.bram_en), 32'd0);
    burst_read1("t2b_ic", 1'b0, 16'h0040);
    @(negedge clk);

    // DC write-back of block 0x0400
    bus1.dc_addr = 16'h0400; bus1.dc_we = 1; bus1.dc_req = 1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      check($sformatf("t3 en k%0d", k), 32'(bus1.bram_en), 32'd1);
      check($sformatf("t3 we k%0d", k), 32'(bus1.bram_we), 32'd1);
      check($sformatf("t3 wnext k%0d", k), 32'(bus1.dc_wnext), 32'd1);
      check($sformatf("t3 woffset k%0d", k), 32'(bus1.dc_woffset), 32'(k - 1));
      check($sformatf("t3 addr k%0d", k), 32'(bus1.bram_addr), 32'h0400 + 32'(k - 1));
      check($sformatf("t3 dc_last k%0d", k), 32'(bus1.dc_last), 32'(k == 32));
      check($sformatf("t3 dc_valid k%0d", k), 32'(bus1.dc_read_valid), 32'd0);
      check($sformatf("t3 ic_valid k%0d", k), 32'(bus1.ic_read_valid), 32'd0);
      if (k == 32) bus1.dc_req = 0;
    end
    @(negedge clk);
    check_quiet1("t3 after");
    for (int i = 0; i < 32; i++) begin
      check($sformatf("t3 mem %0d", i), mem1[16'h0400 + 16'(i)], 32'hD000_0000 + 32'(i));
    end
    bus1.dc_we = 0;

    // unaligned IC address, requested in the IDLE cycle right after the write
    bus1.ic_addr = 16'h013F; bus1.ic_req = 1;
    burst_read1("t6", 1'b0, 16'h0120);
    @(negedge clk);

    // READ_LATENCY=2 instance: tie, IC then DC
    bus2.ic_addr = 16'h0080; bus2.dc_addr = 16'h0280;
    bus2.ic_req = 1; bus2.dc_req = 1;
    first_en = -1; first_icv = -1; ic_last_k = -1; dc_first_en = -1; dc_last_k = -1;
    icv_cnt = 0; icd_ok = 0; dcv_cnt = 0;
    for (int k = 1; k <= 75; k++) begin
      @(negedge clk);
      if (bus2.bram_en && first_en < 0) first_en = k;
      if (bus2.ic_read_valid) begin
        if (first_icv < 0) first_icv = k;
        ea = 16'h0080 + 16'(icv_cnt);
        if (bus2.ic_read === (32'hA5A5_0000 | {16'h0, ea})) icd_ok++;
        icv_cnt++;
      end
      if (bus2.dc_read_valid) dcv_cnt++;
      if (bus2.ic_last) begin ic_last_k = k; bus2.ic_req = 0; end
      if (bus2.bram_en && bus2.bram_addr == 16'h0280 && dc_first_en < 0) dc_first_en = k;
      if (bus2.dc_last) begin dc_last_k = k; bus2.dc_req = 0; end
    end
    check("t4 first_en", 32'(first_en), 32'd1);
    check("t4 first_ic_valid", 32'(first_icv), 32'd3);
    check("t4 ic_valid_count", 32'(icv_cnt), 32'd32);
    check("t4 ic_data_ok", 32'(icd_ok), 32'd32);
    check("t4 ic_last_cycle", 32'(ic_last_k), 32'd34);
    check("t4 dc_first_en", 32'(dc_first_en), 32'd36);
    check("t4 dc_valid_count", 32'(dcv_cnt), 32'd32);
    check("t4 dc_last_cycle", 32'(dc_last_k), 32'd69);

    // reset while IC read is returning word 10
    bus1.ic_addr = 16'h0300; bus1.ic_req = 1;
    repeat (12) @(negedge clk);
    check("t5 word10 valid", 32'(bus1.ic_read_valid), 32'd1);
    check("t5 word10 data", bus1.ic_read, 32'hA5A5_030A);
    rst = 1'b1;
    #1;
    check_quiet1("t5 in_reset");
    bus1.ic_req = 0;
    @(negedge clk);
    check_quiet1("t5 held");
    rst = 1'b0;
    bus1.dc_addr = 16'h0200; bus1.dc_we = 0; bus1.dc_req = 1;
    burst_read1("t5_dc", 1'b1, 16'h0200);
    @(negedge clk);
    check_quiet1("t5 end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
